// File: rtl/key_pkg.sv
// Shared types and 50 MHz default timing constants for the key debouncer.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        PRESSED    = 2'd2,
        REL_FILT   = 2'd3
    } key_state_e;

    localparam int unsigned CNT_W  = 20;
    localparam int unsigned LONG_W = 26;

    // 20 ms debounce window and 1 s long-press hold at 50 MHz, both minus one.
    localparam logic [CNT_W-1:0]  CNT_MAX_DEF  = 20'd999_999;
    localparam logic [LONG_W-1:0] LONG_MAX_DEF = 26'd49_999_999;

endpackage

// File: rtl/key_filter.sv
// Single-key debouncer: 2-flop synchroniser, 4-state filter FSM, registered
// press/release pulses, debounced level and press toggle.
// Optional long-press detector enabled by defining KEY_LONG_PRESS_EN.
module key_filter
    import key_pkg::*;
#(
    parameter logic [CNT_W-1:0]  CNT_MAX  = CNT_MAX_DEF,
    parameter logic [LONG_W-1:0] LONG_MAX = LONG_MAX_DEF
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_press,
    output logic key_release,
    output logic key_level,
    output logic key_toggle,
    output logic key_long
);

    key_state_e       state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             sync1_d, sync1_q;
    logic             sync2_d, sync2_q;
    logic             press_d, press_q;
    logic             release_d, release_q;
    logic             level_d, level_q;
    logic             toggle_d, toggle_q;

    // Next-state, counter and output decode for the debounce filter.
    always_comb begin
        sync1_d   = key_in;
        sync2_d   = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        toggle_d  = toggle_q;

        unique case (state_q)
            IDLE: begin
                if (!sync2_q) begin
                    state_d = PRESS_FILT;
                end
            end
            PRESS_FILT: begin
                if (sync2_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = PRESSED;
                    press_d  = 1'b1;
                    toggle_d = ~toggle_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (sync2_q) begin
                    state_d = REL_FILT;
                end
            end
            REL_FILT: begin
                if (!sync2_q) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Every state entry restarts the window, so the counter never wraps.
        if (state_d != state_q) begin
            cnt_d = '0;
        end

        level_d = (state_d == PRESSED) || (state_d == REL_FILT);
    end

    // State, synchroniser and output registers.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            level_q   <= 1'b0;
            toggle_q  <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            level_q   <= level_d;
            toggle_q  <= toggle_d;
        end
    end

    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_level   = level_q;
    assign key_toggle  = toggle_q;

`ifdef KEY_LONG_PRESS_EN
    logic [LONG_W-1:0] hold_d, hold_q;
    logic              done_d, done_q;
    logic              long_d, long_q;

    // Hold counter: cleared only on a real press (not a release bounce),
    // saturates at LONG_MAX; the one-shot fires when it is seen saturated.
    always_comb begin
        hold_d = hold_q;
        done_d = done_q;
        long_d = 1'b0;
        if ((state_q == PRESS_FILT) && (state_d == PRESSED)) begin
            hold_d = '0;
            done_d = 1'b0;
        end else if ((state_q == PRESSED) || (state_q == REL_FILT)) begin
            if (hold_q != LONG_MAX) begin
                hold_d = hold_q + 1'b1;
            end else if (!done_q) begin
                long_d = 1'b1;
                done_d = 1'b1;
            end
        end
    end

    // Long-press registers.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            hold_q <= '0;
            done_q <= 1'b0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            done_q <= done_d;
            long_q <= long_d;
        end
    end

    assign key_long = long_q;
`else
    logic unused_long;
    assign unused_long = ^LONG_MAX;
    assign key_long    = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Key bank debouncer: one independent key_filter per key.
// Long-press outputs are active only when KEY_LONG_PRESS_EN is defined.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned       KEY_NUM  = 4,
    parameter logic [CNT_W-1:0]  CNT_MAX  = CNT_MAX_DEF,
    parameter logic [LONG_W-1:0] LONG_MAX = LONG_MAX_DEF
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_level,
    output logic [KEY_NUM-1:0] key_toggle,
    output logic [KEY_NUM-1:0] key_long
);

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
        key_filter #(
            .CNT_MAX  (CNT_MAX),
            .LONG_MAX (LONG_MAX)
        ) u_key_filter (
            .sys_clk     (sys_clk),
            .rst_n       (rst_n),
            .key_in      (key_in[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_level   (key_level[i]),
            .key_toggle  (key_toggle[i]),
            .key_long    (key_long[i])
        );
    end

endmodule
